// File: rtl/reg_bank_if.sv
// Register-file access bus: the control unit drives sel/write_reg, the datapath
// drives data_in and consumes data_out.
interface reg_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_reg;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output sel,
        output data_in,
        output write_reg,
        input  data_out
    );

    modport slave (
        input  sel,
        input  data_in,
        input  write_reg,
        output data_out
    );
endinterface

// File: rtl/reg_bank.sv
// 32 x 8 single-port register file with a hardwired zero register r0,
// synchronous write and combinational read through one shared address.
module reg_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_bank_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write_reg && (bus.sel != '0)) begin
            regs[bus.sel] <= bus.data_in;
        end
    end

    // No bypass from data_in: a write becomes visible after the edge.
    assign bus.data_out = (bus.sel == '0) ? '0 : regs[bus.sel];
endmodule

// File: tb/tb_reg_bank.sv
// Directed checks of reg_bank: reset, zero register, write enable, full
// address range, combinational read and mid-run asynchronous reset.
module tb_reg_bank;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    reg_bank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

    reg_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sel = 5'd0;
        bus.data_in = 8'h00;
        bus.write_reg = 1'b0;
        #2;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sel0 got %h exp %h", bus.data_out, 8'h00);
        end
        bus.sel = 5'd5;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sel5 got %h exp %h", bus.data_out, 8'h00);
        end
        bus.sel = 5'd31;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sel31 got %h exp %h", bus.data_out, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        bus.sel = 5'd1;
        bus.data_in = 8'h05;
        bus.write_reg = 1'b1;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_write_no_bypass got %h exp %h", bus.data_out, 8'h00);
        end
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h05) begin
            n_fail++;
            $display("FAIL basic_write_edge1 got %h exp %h", bus.data_out, 8'h05);
        end
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h05) begin
            n_fail++;
            $display("FAIL basic_write_edge2 got %h exp %h", bus.data_out, 8'h05);
        end
    endtask

    task automatic test_write_disable();
        bus.sel = 5'd1;
        bus.data_in = 8'hFF;
        bus.write_reg = 1'b0;
        edge_step();
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h05) begin
            n_fail++;
            $display("FAIL write_disable got %h exp %h", bus.data_out, 8'h05);
        end
    endtask

    task automatic test_zero_register();
        bus.sel = 5'd0;
        bus.data_in = 8'h05;
        bus.write_reg = 1'b1;
        edge_step();
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_register got %h exp %h", bus.data_out, 8'h00);
        end
        bus.write_reg = 1'b0;
    endtask

    task automatic test_full_range();
        logic [7:0] exp_val;
        logic [7:0] idx;
        for (int i = 1; i < 32; i++) begin
            idx = 8'(i);
            bus.sel = 5'(i);
            bus.data_in = idx ^ 8'h5A;
            bus.write_reg = 1'b1;
            edge_step();
        end
        bus.write_reg = 1'b0;
        bus.data_in = 8'h00;
        for (int i = 0; i < 32; i++) begin
            idx = 8'(i);
            exp_val = (i == 0) ? 8'h00 : (idx ^ 8'h5A);
            bus.sel = 5'(i);
            #1;
            n_checks++;
            if (bus.data_out !== exp_val) begin
                n_fail++;
                $display("FAIL full_range r%0d got %h exp %h", i, bus.data_out, exp_val);
            end
        end
        bus.sel = 5'd31;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h45) begin
            n_fail++;
            $display("FAIL boundary_r31 got %h exp %h", bus.data_out, 8'h45);
        end
        bus.sel = 5'd1;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h5B) begin
            n_fail++;
            $display("FAIL boundary_r1 got %h exp %h", bus.data_out, 8'h5B);
        end
    endtask

    task automatic test_comb_read();
        @(negedge clk);
        bus.sel = 5'd2;
        bus.data_in = 8'h33;
        bus.write_reg = 1'b1;
        edge_step();
        bus.sel = 5'd3;
        bus.data_in = 8'hCC;
        edge_step();
        bus.write_reg = 1'b0;
        bus.data_in = 8'h00;
        for (int k = 0; k < 2; k++) begin
            bus.sel = 5'd2;
            #1;
            n_checks++;
            if (bus.data_out !== 8'h33) begin
                n_fail++;
                $display("FAIL comb_read_r2 got %h exp %h", bus.data_out, 8'h33);
            end
            bus.sel = 5'd3;
            #1;
            n_checks++;
            if (bus.data_out !== 8'hCC) begin
                n_fail++;
                $display("FAIL comb_read_r3 got %h exp %h", bus.data_out, 8'hCC);
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        bus.sel = 5'd5;
        bus.data_in = 8'hA5;
        bus.write_reg = 1'b1;
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL midrun_write_r5 got %h exp %h", bus.data_out, 8'hA5);
        end
        // Keep a write pending so the reset must also win at the next edge.
        bus.data_in = 8'h77;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_reset_async got %h exp %h", bus.data_out, 8'h00);
        end
        bus.sel = 5'd2;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_reset_r2 got %h exp %h", bus.data_out, 8'h00);
        end
        bus.sel = 5'd5;
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_priority got %h exp %h", bus.data_out, 8'h00);
        end
        @(negedge clk);
        bus.write_reg = 1'b0;
        rst_n = 1'b1;
        edge_step();
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset_r5 got %h exp %h", bus.data_out, 8'h00);
        end
        bus.sel = 5'd31;
        #1;
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset_r31 got %h exp %h", bus.data_out, 8'h00);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic_write();
        test_write_disable();
        test_zero_register();
        test_full_range();
        test_comb_read();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
